// File: rtl/hall_call_manager.sv
// Hall call manager: latches per-floor up/down hall calls, drives the lamps and
// offers undispatched calls to the building controller in round-robin order.
module hall_call_manager #(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] hall_req,
    input  logic [NUM_FLOORS-1:0] hall_dir_up_ndown,
    output logic                  call_valid,
    output logic [FLOOR_W-1:0]    call_floor,
    output logic                  call_dir_up_ndown,
    input  logic                  call_ready,
    input  logic                  clear_valid,
    input  logic [FLOOR_W-1:0]    clear_floor,
    input  logic                  clear_dir_up_ndown,
    output logic [NUM_FLOORS-1:0] lamp_up,
    output logic [NUM_FLOORS-1:0] lamp_down,
    output logic [3:0]            pending_count
);

    localparam int unsigned NUM_ENTRIES = 2 * NUM_FLOORS;
    localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                 state;
    logic [NUM_ENTRIES-1:0] pending;
    logic [NUM_ENTRIES-1:0] dispatched;
    logic [NUM_ENTRIES-1:0] req_mask;
    logic [NUM_ENTRIES-1:0] clr_mask;
    logic [NUM_ENTRIES-1:0] cand;
    logic [NUM_ENTRIES-1:0] pending_next;
    logic [NUM_ENTRIES-1:0] dispatched_next;
    logic [IDX_W-1:0]       last_granted;
    logic [IDX_W-1:0]       offer_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic                   found;
    logic                   withdraw;
    logic                   accept;
    logic [3:0]             count_next;

    // Entry index = 2*floor + dir; top-floor up and ground-floor down never exist.
    always_comb begin
        req_mask = '0;
        clr_mask = '0;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (hall_req[f]) begin
                if (hall_dir_up_ndown[f]) begin
                    if (f != NUM_FLOORS - 1) req_mask[2*f+1] = 1'b1;
                end else if (f != 0) begin
                    req_mask[2*f] = 1'b1;
                end
            end
            if (clear_valid && clear_floor == FLOOR_W'(f)) begin
                if (clear_dir_up_ndown) clr_mask[2*f+1] = 1'b1;
                else                    clr_mask[2*f]   = 1'b1;
            end
        end
    end

    // Entries being cleared this cycle are not eligible for a fresh offer.
    always_comb begin
        int unsigned j;
        j       = 0;
        cand    = pending & ~dispatched & ~clr_mask;
        found   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 1; i <= NUM_ENTRIES; i++) begin
            j = (32'(last_granted) + i) % NUM_ENTRIES;
            if (!found && cand[j]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(j);
            end
        end
    end

    // A clear of the offered entry withdraws the offer even if call_ready is high.
    always_comb begin
        withdraw        = (state == OFFER) && clr_mask[offer_idx];
        accept          = (state == OFFER) && call_ready && !withdraw;
        pending_next    = (pending | req_mask) & ~clr_mask;
        dispatched_next = dispatched & ~clr_mask;
        if (accept) dispatched_next[offer_idx] = 1'b1;
        count_next = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            count_next = count_next + 4'(pending_next[i]);
        end
    end

    always_comb begin
        lamp_up   = '0;
        lamp_down = '0;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            lamp_up[f]   = pending[2*f+1];
            lamp_down[f] = pending[2*f];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            pending           <= '0;
            dispatched        <= '0;
            last_granted      <= IDX_W'(NUM_ENTRIES - 1);
            offer_idx         <= '0;
            call_valid        <= 1'b0;
            call_floor        <= '0;
            call_dir_up_ndown <= 1'b0;
            pending_count     <= '0;
        end else begin
            pending       <= pending_next;
            dispatched    <= dispatched_next;
            pending_count <= count_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        state             <= OFFER;
                        call_valid        <= 1'b1;
                        offer_idx         <= sel_idx;
                        call_floor        <= FLOOR_W'(sel_idx >> 1);
                        call_dir_up_ndown <= sel_idx[0];
                    end
                end
                OFFER: begin
                    if (withdraw || accept) begin
                        state      <= IDLE;
                        call_valid <= 1'b0;
                        if (accept) last_granted <= offer_idx;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hall_call_manager.sv
// Bench for hall_call_manager: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a floor/direction table model.
module tb_hall_call_manager;

    logic       clk;
    logic       reset;
    logic [6:0] hall_req;
    logic [6:0] hall_dir_up_ndown;
    logic       call_valid;
    logic [2:0] call_floor;
    logic       call_dir_up_ndown;
    logic       call_ready;
    logic       clear_valid;
    logic [2:0] clear_floor;
    logic       clear_dir_up_ndown;
    logic [6:0] lamp_up;
    logic [6:0] lamp_down;
    logic [3:0] pending_count;

    int checks = 0;
    int passes = 0;

    hall_call_manager #(.NUM_FLOORS(7), .FLOOR_W(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .hall_req           (hall_req),
        .hall_dir_up_ndown  (hall_dir_up_ndown),
        .call_valid         (call_valid),
        .call_floor         (call_floor),
        .call_dir_up_ndown  (call_dir_up_ndown),
        .call_ready         (call_ready),
        .clear_valid        (clear_valid),
        .clear_floor        (clear_floor),
        .clear_dir_up_ndown (clear_dir_up_ndown),
        .lamp_up            (lamp_up),
        .lamp_down          (lamp_down),
        .pending_count      (pending_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Reference model: call table indexed [floor][dir], offer as (floor, dir),
    // round-robin pointer as a plain integer entry number 2*floor+dir.
    bit pend [7][2];
    bit disp [7][2];
    bit offering;
    int of, od;
    int last;
    bit model_on = 1'b0;

    always @(posedge clk) begin
        int  cf, cd, e, f, d;
        bit  clr_on;
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                pend[i][0] = 0; pend[i][1] = 0; disp[i][0] = 0; disp[i][1] = 0;
            end
            offering = 0; of = 0; od = 0; last = 13; model_on = 1'b1;
        end else begin
            clr_on = clear_valid && (int'(clear_floor) < 7);
            cf = int'(clear_floor);
            cd = int'(clear_dir_up_ndown);
            if (offering) begin
                if (clr_on && cf == of && cd == od) offering = 0;
                else if (call_ready) begin
                    offering = 0;
                    disp[of][od] = 1;
                    last = 2 * of + od;
                end
            end else begin
                for (int k = 1; k <= 14; k++) begin
                    e = (last + k) % 14;
                    f = e / 2;
                    d = e % 2;
                    if (!offering && pend[f][d] && !disp[f][d] && !(clr_on && cf == f && cd == d)) begin
                        offering = 1; of = f; od = d;
                    end
                end
            end
            for (int i = 0; i < 7; i++) begin
                if (hall_req[i]) begin
                    d = int'(hall_dir_up_ndown[i]);
                    if (!(i == 6 && d == 1) && !(i == 0 && d == 0)) pend[i][d] = 1;
                end
            end
            if (clr_on) begin
                pend[cf][cd] = 0;
                disp[cf][cd] = 0;
            end
        end
    end

    always @(negedge clk) begin
        int eu, ed, ec;
        if (model_on) begin
            eu = 0; ed = 0; ec = 0;
            for (int i = 0; i < 7; i++) begin
                eu += int'(pend[i][1]) << i;
                ed += int'(pend[i][0]) << i;
                ec += int'(pend[i][0]) + int'(pend[i][1]);
            end
            chk("m_call_valid", int'(call_valid), int'(offering));
            if (offering) begin
                chk("m_call_floor", int'(call_floor), of);
                chk("m_call_dir", int'(call_dir_up_ndown), od);
            end
            chk("m_lamp_up", int'(lamp_up), eu);
            chk("m_lamp_down", int'(lamp_down), ed);
            chk("m_pending_count", int'(pending_count), ec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hall_req = '0; hall_dir_up_ndown = '0;
        clear_valid = 1'b0; clear_floor = '0; clear_dir_up_ndown = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        int seq[$];
        reset = 1'b1;
        call_ready = 1'b0;
        idle_inputs();
        do_reset();

        chk("rst_call_valid", int'(call_valid), 0);
        chk("rst_call_floor", int'(call_floor), 0);
        chk("rst_lamps", int'({lamp_up, lamp_down}), 0);
        chk("rst_count", int'(pending_count), 0);

        // Single up call at floor 3
        hall_req[3] = 1'b1; hall_dir_up_ndown[3] = 1'b1;
        tick(); idle_inputs();
        chk("f3_lamp_up", int'(lamp_up), 8);
        chk("f3_count_n1", int'(pending_count), 1);
        chk("f3_valid_n1", int'(call_valid), 0);
        tick();
        chk("f3_valid_n2", int'(call_valid), 1);
        chk("f3_floor", int'(call_floor), 3);
        chk("f3_dir", int'(call_dir_up_ndown), 1);
        chk("f3_count_n2", int'(pending_count), 1);
        call_ready = 1'b1;
        tick(); call_ready = 1'b0;
        chk("f3_accepted", int'(call_valid), 0);
        tick();
        chk("f3_no_reoffer", int'(call_valid), 0);
        clear_valid = 1'b1; clear_floor = 3'd3; clear_dir_up_ndown = 1'b1;
        tick(); idle_inputs();
        chk("f3_cleared", int'(pending_count), 0);

        // Non-existent directions at the end floors
        hall_req = 7'b1000001; hall_dir_up_ndown = 7'b1000000;
        tick(); idle_inputs();
        chk("edge_lamps", int'({lamp_up, lamp_down}), 0);
        chk("edge_count", int'(pending_count), 0);
        tick();
        chk("edge_valid", int'(call_valid), 0);

        // Round-robin order from a fresh pointer
        do_reset();
        hall_req = 7'b0100110; hall_dir_up_ndown = 7'b0100010;
        call_ready = 1'b1;
        tick(); idle_inputs();
        repeat (10) begin
            tick();
            if (call_valid) seq.push_back(int'(call_floor) * 2 + int'(call_dir_up_ndown));
        end
        call_ready = 1'b0;
        chk("rr_offers", seq.size(), 3);
        if (seq.size() == 3) begin
            chk("rr_first", seq[0], 3);
            chk("rr_second", seq[1], 4);
            chk("rr_third", seq[2], 11);
        end
        chk("rr_count", int'(pending_count), 3);

        // Held offer then withdrawal by clear
        do_reset();
        hall_req[4] = 1'b1; hall_dir_up_ndown[4] = 1'b0;
        tick(); idle_inputs();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", int'(call_valid), 1);
            chk("hold_floor", int'(call_floor), 4);
            chk("hold_dir", int'(call_dir_up_ndown), 0);
            tick();
        end
        clear_valid = 1'b1; clear_floor = 3'd4; clear_dir_up_ndown = 1'b0;
        tick(); idle_inputs();
        chk("wd_valid", int'(call_valid), 0);
        chk("wd_lamp_down", int'(lamp_down), 0);
        chk("wd_count", int'(pending_count), 0);

        // Clear beats a simultaneous request; reset aborts an offer
        do_reset();
        hall_req[2] = 1'b1; hall_dir_up_ndown[2] = 1'b1;
        clear_valid = 1'b1; clear_floor = 3'd2; clear_dir_up_ndown = 1'b1;
        tick(); idle_inputs();
        chk("clrpri_lamp_up", int'(lamp_up), 0);
        chk("clrpri_count", int'(pending_count), 0);
        hall_req[5] = 1'b1; hall_dir_up_ndown[5] = 1'b0;
        tick(); idle_inputs();
        tick();
        chk("pre_rst_valid", int'(call_valid), 1);
        reset = 1'b1;
        hall_req[1] = 1'b1; hall_dir_up_ndown[1] = 1'b1;
        tick();
        chk("midrst_valid", int'(call_valid), 0);
        chk("midrst_floor", int'(call_floor), 0);
        chk("midrst_dir", int'(call_dir_up_ndown), 0);
        chk("midrst_lamps", int'({lamp_up, lamp_down}), 0);
        chk("midrst_count", int'(pending_count), 0);
        reset = 1'b0; idle_inputs();
        tick();
        chk("rst_req_dropped", int'(lamp_up), 0);

        // Randomized traffic, checked by the model on every cycle
        for (int c = 0; c < 3000; c++) begin
            hall_req          = ($urandom_range(0, 3) == 0) ? (7'($urandom) & 7'($urandom)) : 7'd0;
            hall_dir_up_ndown = 7'($urandom);
            call_ready        = ($urandom_range(0, 2) != 0);
            clear_valid       = ($urandom_range(0, 2) == 0);
            if (call_valid && $urandom_range(0, 3) == 0) begin
                clear_floor        = call_floor;
                clear_dir_up_ndown = call_dir_up_ndown;
            end else begin
                clear_floor        = 3'($urandom);
                clear_dir_up_ndown = 1'($urandom);
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; idle_inputs(); call_ready = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hall_call_manager.md
HALL_CALL_MANAGER -- requirements
Module: hall_call_manager

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 7, number of served floors (0..NUM_FLOORS-1, top floor 6).
REQ-002 SHALL have parameter FLOOR_W, default 3, width of floor indices.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port hall_req  input  NUM_FLOORS  per-floor registered request from each hall button panel (bit f = floor f).
REQ-006 SHALL have port hall_dir_up_ndown  input  NUM_FLOORS  per-floor direction qualifying hall_req (1 = up, 0 = down).
REQ-007 SHALL have port call_valid  output  1  a hall call is offered to the building controller.
REQ-008 SHALL have port call_floor  output  FLOOR_W  floor of the offered call.
REQ-009 SHALL have port call_dir_up_ndown  output  1  direction of the offered call.
REQ-010 SHALL have port call_ready  input  1  building controller accepts the offered call.
REQ-011 SHALL have port clear_valid  input  1  car has served a hall call this cycle.
REQ-012 SHALL have port clear_floor  input  FLOOR_W  floor being served.
REQ-013 SHALL have port clear_dir_up_ndown  input  1  direction being served.
REQ-014 SHALL have port lamp_up  output  NUM_FLOORS  up-call lamps, one per floor.
REQ-015 SHALL have port lamp_down  output  NUM_FLOORS  down-call lamps, one per floor.
REQ-016 SHALL have port pending_count  output  4  number of pending hall calls.

Function
REQ-017 SHALL hold 14 entries (floor x direction): pending bit and dispatched bit each; entry index = 2*floor + dir.
REQ-018 SHALL set pending[f,dir] on the cycle after hall_req[f]=1; up at floor 6 and down at floor 0 are discarded.
REQ-019 SHALL leave an already-pending entry unchanged on a repeated request (no duplicate dispatch).
REQ-020 SHALL drive lamp_up[f]/lamp_down[f] directly from the pending bits (lamp on 1 cycle after request).
REQ-021 SHALL drive pending_count as the registered popcount of pending bits, range 0..12.
REQ-022 SHALL implement FSM IDLE/OFFER: IDLE -> OFFER when any entry is pending and not dispatched; OFFER -> IDLE on call_valid&call_ready or on withdrawal (REQ-025).
REQ-023 SHALL select the offered entry by round-robin: lowest index strictly above last granted index, wrapping 13 -> 0; last granted resets to 13 so index 0 wins first.
REQ-024 SHALL assert call_valid only in OFFER and hold call_floor/call_dir stable until accepted or withdrawn; earliest call_valid is 2 cycles after hall_req.
REQ-025 SHALL, on acceptance, set the entry's dispatched bit and update last granted; if the offered entry is cleared while in OFFER, deassert call_valid next cycle and return to IDLE without setting dispatched.
REQ-026 SHALL, on clear_valid, clear both pending and dispatched of entry (clear_floor, clear_dir) next cycle; clearing a non-pending entry is a no-op; clear_floor >= NUM_FLOORS is ignored.
REQ-027 SHALL give clear priority over a simultaneous new request to the same entry (entry ends cleared, lamp off).
REQ-028 SHALL apply simultaneous requests on several floors all in the same cycle.
REQ-029 SHALL never re-offer a dispatched entry until it has been cleared and requested again.

Reset
REQ-030 SHALL, while reset is high, clear all pending and dispatched bits, set FSM to IDLE, last granted to 13, call_valid=0, call_floor=0, call_dir_up_ndown=0, lamps=0, pending_count=0.
REQ-031 SHALL abort any outstanding offer on reset mid-operation; requests during reset are discarded.

Verification
REQ-032 SHALL cover: hall_req[3]=1, dir=1 at cycle N -> lamp_up[3]=1 at N+1, pending_count=1, call_valid=1, call_floor=3, dir=1 at N+2.
REQ-033 SHALL cover: hall_req[6] with dir=1 and hall_req[0] with dir=0 -> no lamp, pending_count=0, call_valid stays 0.
REQ-034 SHALL cover: requests floor 2 down, floor 5 up, floor 1 up same cycle, call_ready=1 always -> offers in index order 1 up, 2 down, 5 up, each exactly once.
REQ-035 SHALL cover: call floor 4 down offered with call_ready=0 for 5 cycles -> outputs stable; then clear_valid floor 4 down -> call_valid=0 next cycle, lamp_down[4]=0, pending_count=0.
REQ-036 SHALL cover: clear_valid and hall_req for floor 2 up in same cycle -> lamp_up[2]=0 afterwards; reset asserted during OFFER -> all outputs zero next cycle.
